// File: rtl/microwave_timer_pkg.sv
// Shared definitions for the microwave timer: FSM states, button priority,
// BCD time layout and the digit-wise BCD arithmetic helpers.
package microwave_timer_pkg;

   localparam int unsigned BCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      BTN_NONE    = 3'd0,
      BTN_STOP    = 3'd1,
      BTN_START   = 3'd2,
      BTN_ADD_MIN = 3'd3,
      BTN_ADD_SEC = 3'd4
   } btn_t;

   typedef struct packed {
      logic [BCD_W-1:0] min_t;
      logic [BCD_W-1:0] min_o;
      logic [BCD_W-1:0] sec_t;
      logic [BCD_W-1:0] sec_o;
   } bcd_time_t;

   // Only one button acts per cycle: stop > start > add_min > add_sec.
   function automatic btn_t sel_button(input logic stop, input logic start,
                                       input logic add_min, input logic add_sec);
      btn_t b;
      b = BTN_NONE;
      if (stop)         b = BTN_STOP;
      else if (start)   b = BTN_START;
      else if (add_min) b = BTN_ADD_MIN;
      else if (add_sec) b = BTN_ADD_SEC;
      return b;
   endfunction

   function automatic bcd_time_t add_minute(input bcd_time_t t,
                                            input logic [BCD_W-1:0] max_t,
                                            input logic [BCD_W-1:0] max_o);
      bcd_time_t r;
      r = t;
      if (!(t.min_t == max_t && t.min_o == max_o)) begin
         if (t.min_o == 4'd9) begin
            r.min_t = t.min_t + 4'd1;
            r.min_o = 4'd0;
         end else begin
            r.min_o = t.min_o + 4'd1;
         end
      end
      return r;
   endfunction

   function automatic bcd_time_t add_ten_sec(input bcd_time_t t,
                                             input logic [BCD_W-1:0] max_t,
                                             input logic [BCD_W-1:0] max_o);
      bcd_time_t r;
      r = t;
      if (t.sec_t < 4'd5) begin
         r.sec_t = t.sec_t + 4'd1;
      end else if (t.min_t == max_t && t.min_o == max_o) begin
         r.sec_t = 4'd5;
         r.sec_o = 4'd9;
      end else begin
         r       = add_minute(t, max_t, max_o);
         r.sec_t = t.sec_t - 4'd5;
      end
      return r;
   endfunction

   function automatic bcd_time_t dec_second(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.sec_o != 4'd0) begin
         r.sec_o = t.sec_o - 4'd1;
      end else if (t.sec_t != 4'd0) begin
         r.sec_t = t.sec_t - 4'd1;
         r.sec_o = 4'd9;
      end else begin
         r.sec_t = 4'd5;
         r.sec_o = 4'd9;
         if (t.min_o != 4'd0) begin
            r.min_o = t.min_o - 4'd1;
         end else begin
            r.min_t = t.min_t - 4'd1;
            r.min_o = 4'd9;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/microwave_timer_tick_edge_detect.sv
// Synchronises the 1 Hz level and emits a one-cycle pulse per rising edge.
module tick_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic s1, s2, s3;

   // Flops reset high so a level already high at reset is not seen as an edge;
   // the pulse is registered, putting the count update on the 4th edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         s3    <= 1'b1;
         pulse <= 1'b0;
      end else begin
         s1    <= level;
         s2    <= s1;
         s3    <= s2;
         pulse <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/microwave_timer.sv
// Microwave countdown timer: BCD minutes/seconds, button handling and the
// IDLE/RUNNING/PAUSED/DONE control FSM.
module microwave_timer
   import microwave_timer_pkg::*;
#(
   parameter int unsigned MAX_MIN     = 99,
   parameter int unsigned DONE_HOLD_S = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_add_min,
   input  logic       btn_add_sec,
   input  logic       btn_start,
   input  logic       btn_stop,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done
);

   localparam logic [BCD_W-1:0] MAX_T     = BCD_W'(MAX_MIN / 10);
   localparam logic [BCD_W-1:0] MAX_O     = BCD_W'(MAX_MIN % 10);
   localparam logic [7:0]       HOLD_LAST = 8'(DONE_HOLD_S - 1);

   state_t    state, state_n;
   bcd_time_t tm, tm_n, tm_dec;
   logic      pending, pend_n;
   logic [7:0] hold_cnt, hold_n;
   btn_t      btn;
   logic      tick_p;

   tick_edge_detect u_tick (
      .clk   (clk),
      .reset (reset),
      .level (tick_1hz),
      .pulse (tick_p)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         tm       <= '0;
         pending  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         tm       <= tm_n;
         pending  <= pend_n;
         hold_cnt <= hold_n;
      end
   end

   always_comb begin
      state_n = state;
      tm_n    = tm;
      pend_n  = 1'b0;
      hold_n  = '0;
      tm_dec  = dec_second(tm);
      btn     = sel_button(btn_stop, btn_start, btn_add_min, btn_add_sec);
      case (state)
         ST_IDLE: begin
            case (btn)
               BTN_STOP:    tm_n = '0;
               BTN_START:   if (tm != '0) state_n = ST_RUNNING;
               BTN_ADD_MIN: tm_n = add_minute(tm, MAX_T, MAX_O);
               BTN_ADD_SEC: tm_n = add_ten_sec(tm, MAX_T, MAX_O);
               default:     ;
            endcase
         end
         ST_RUNNING: begin
            pend_n = pending;
            if (btn == BTN_STOP) begin
               state_n = ST_PAUSED;
               pend_n  = 1'b0;
            end else if (btn == BTN_ADD_MIN || btn == BTN_ADD_SEC) begin
               // A tick colliding with an add is deferred, never lost.
               tm_n   = (btn == BTN_ADD_MIN) ? add_minute(tm, MAX_T, MAX_O)
                                             : add_ten_sec(tm, MAX_T, MAX_O);
               pend_n = pending | tick_p;
            end else if (tick_p || pending) begin
               pend_n = tick_p & pending;
               if (tm == '0 || tm_dec == '0) begin
                  state_n = ST_DONE;
                  tm_n    = '0;
                  pend_n  = 1'b0;
               end else begin
                  tm_n = tm_dec;
               end
            end
         end
         ST_PAUSED: begin
            case (btn)
               BTN_STOP: begin
                  state_n = ST_IDLE;
                  tm_n    = '0;
               end
               BTN_START:   state_n = ST_RUNNING;
               BTN_ADD_MIN: tm_n = add_minute(tm, MAX_T, MAX_O);
               BTN_ADD_SEC: tm_n = add_ten_sec(tm, MAX_T, MAX_O);
               default:     ;
            endcase
         end
         ST_DONE: begin
            tm_n   = '0;
            hold_n = hold_cnt;
            if (btn != BTN_NONE) begin
               state_n = ST_IDLE;
               hold_n  = '0;
            end else if (tick_p) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_n = ST_IDLE;
                  hold_n  = '0;
               end else begin
                  hold_n = hold_cnt + 8'd1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign min_bcd = {tm.min_t, tm.min_o};
   assign sec_bcd = {tm.sec_t, tm.sec_o};
   assign running = (state == ST_RUNNING);
   assign done    = (state == ST_DONE);

endmodule
